// File: rtl/led_bcm_scan.sv
// HUB75-style LED matrix scanner: fetches pixels from an external frame buffer, shifts NUM_CH
// RGB lanes per column and drives rows with binary-coded modulation, dead time and bank swap.
module led_bcm_scan #(
  parameter int NUM_CH    = 4,
  parameter int COLS      = 16,
  parameter int ROW_BITS  = 3,
  parameter int PWM_DEPTH = 8,
  parameter int CLK_DIV   = 2,
  parameter int BASE_ON   = 8,
  parameter int BLANK_CYC = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              swap_req,
  output logic                              fb_rd,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  fb_addr,
  output logic                              fb_sel,
  input  logic [NUM_CH*3*PWM_DEPTH-1:0]     fb_rdata,
  output logic [NUM_CH-1:0]                 led_r,
  output logic [NUM_CH-1:0]                 led_g,
  output logic [NUM_CH-1:0]                 led_b,
  output logic                              led_clk,
  output logic                              led_stb,
  output logic                              led_oe,
  output logic [ROW_BITS-1:0]               led_row,
  output logic                              frame_end,
  output logic                              swap_ack
);

  localparam int D     = PWM_DEPTH;
  localparam int S     = 2 + 2 * CLK_DIV;
  localparam int COL_W = $clog2(COLS);
  localparam int K_W   = $clog2(S);
  localparam int PL_W  = (D > 1) ? $clog2(D) : 1;
  localparam int ON_W  = $clog2(BASE_ON << (D - 1)) + 1;
  localparam int BL_W  = $clog2(BLANK_CYC) + 1;
  localparam int CNT_W = (ON_W > BL_W) ? ON_W : BL_W;

  localparam logic [K_W-1:0]   K_DATA     = K_W'(1);
  localparam logic [K_W-1:0]   K_RISE     = K_W'(CLK_DIV + 2);
  localparam logic [K_W-1:0]   K_LAST     = K_W'(S - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PL_W-1:0]  PL_LAST    = PL_W'(D - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    LATCH = 3'd2,
    BLANK = 3'd3,
    SHOW  = 3'd4
  } state_t;

  state_t               state_r;
  logic [ROW_BITS-1:0]  row_r;
  logic [PL_W-1:0]      plane_r;
  logic [COL_W-1:0]     col_r;
  logic [K_W-1:0]       k_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 pend_r;

  logic [NUM_CH-1:0]    r_bit_s, g_bit_s, b_bit_s;
  logic [D-1:0]         r_f_s, g_f_s, b_f_s;
  logic                 last_plane_s, frame_last_s;
  logic [PL_W-1:0]      nxt_plane_s;
  logic [ROW_BITS-1:0]  nxt_row_s;
  logic [CNT_W-1:0]     on_last_s;

  // Select the current bit plane out of each lane's {B,G,R} word.
  always_comb begin
    r_bit_s = '0;
    g_bit_s = '0;
    b_bit_s = '0;
    r_f_s   = '0;
    g_f_s   = '0;
    b_f_s   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      r_f_s       = fb_rdata[ch*3*D +: D];
      g_f_s       = fb_rdata[ch*3*D + D +: D];
      b_f_s       = fb_rdata[ch*3*D + 2*D +: D];
      r_bit_s[ch] = r_f_s[plane_r];
      g_bit_s[ch] = g_f_s[plane_r];
      b_bit_s[ch] = b_f_s[plane_r];
    end
  end

  // Next row/plane position and the length of the current plane's on-time.
  always_comb begin
    last_plane_s = (plane_r == PL_LAST);
    nxt_plane_s  = last_plane_s ? PL_W'(0) : plane_r + PL_W'(1);
    nxt_row_s    = last_plane_s ? row_r + ROW_BITS'(1) : row_r;
    frame_last_s = last_plane_s && (row_r == {ROW_BITS{1'b1}});
    on_last_s    = (CNT_W'(BASE_ON) << plane_r) - CNT_W'(1);
  end

  // Scan sequencer; outputs are set on the edge that enters the cycle they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      row_r     <= '0;
      plane_r   <= '0;
      col_r     <= '0;
      k_r       <= '0;
      cnt_r     <= '0;
      pend_r    <= 1'b0;
      fb_rd     <= 1'b0;
      fb_addr   <= '0;
      fb_sel    <= 1'b0;
      led_r     <= '0;
      led_g     <= '0;
      led_b     <= '0;
      led_clk   <= 1'b0;
      led_stb   <= 1'b0;
      led_oe    <= 1'b1;
      led_row   <= '0;
      frame_end <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      fb_rd     <= 1'b0;
      led_stb   <= 1'b0;
      frame_end <= 1'b0;
      swap_ack  <= 1'b0;
      if (swap_req) pend_r <= 1'b1;
      case (state_r)
        IDLE: begin
          led_oe  <= 1'b1;
          led_clk <= 1'b0;
          if (en) begin
            state_r <= SHIFT;
            col_r   <= '0;
            k_r     <= '0;
            fb_rd   <= 1'b1;
            fb_addr <= {row_r, COL_W'(0)};
          end
        end
        SHIFT: begin
          if (k_r == K_DATA) begin
            led_r <= r_bit_s;
            led_g <= g_bit_s;
            led_b <= b_bit_s;
          end
          if (k_r == K_LAST) begin
            k_r     <= '0;
            led_clk <= 1'b0;
            if (col_r == COL_LAST) begin
              state_r <= LATCH;
              led_stb <= 1'b1;
              led_row <= row_r;
            end else begin
              col_r   <= col_r + COL_W'(1);
              fb_rd   <= 1'b1;
              fb_addr <= {row_r, col_r + COL_W'(1)};
            end
          end else begin
            k_r     <= k_r + K_W'(1);
            led_clk <= ((k_r + K_W'(1)) >= K_RISE);
          end
        end
        LATCH: begin
          state_r <= BLANK;
          cnt_r   <= '0;
        end
        BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_r <= SHOW;
            cnt_r   <= '0;
            led_oe  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_r == on_last_s) begin
            led_oe  <= 1'b1;
            plane_r <= nxt_plane_s;
            row_r   <= nxt_row_s;
            cnt_r   <= '0;
            // Bank swap only at the frame boundary so a frame never mixes banks.
            if (frame_last_s) begin
              frame_end <= 1'b1;
              if (pend_r || swap_req) begin
                fb_sel   <= ~fb_sel;
                swap_ack <= 1'b1;
                pend_r   <= 1'b0;
              end
            end
            if (en) begin
              state_r <= SHIFT;
              col_r   <= '0;
              k_r     <= '0;
              fb_rd   <= 1'b1;
              fb_addr <= {nxt_row_s, COL_W'(0)};
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          led_oe  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bcm_scan.sv
// Self-checking bench for led_bcm_scan: random frame-buffer contents checked against a
// unit-level model of the scan order, BCM on-times, unit lengths and bank swapping.
module tb_led_bcm_scan;
  localparam int NUM_CH = 1, COLS = 4, ROW_BITS = 1, D = 2, CLK_DIV = 2, BASE_ON = 4, BLANK_CYC = 2;
  localparam int S = 2 + 2 * CLK_DIV;
  localparam int AW = ROW_BITS + 2;
  localparam int DW = NUM_CH * 3 * D;
  localparam int SHIFT_LEN = COLS * S;
  localparam int FRAME_LEN = 2 * (SHIFT_LEN + 1 + BLANK_CYC) * 2 + 2 * (BASE_ON + (BASE_ON << 1));

  logic clk, reset, en, swap_req;
  logic fb_rd, fb_sel, led_clk, led_stb, led_oe, frame_end, swap_ack;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_rdata;
  logic [NUM_CH-1:0] led_r, led_g, led_b;
  logic [ROW_BITS-1:0] led_row;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int total = 0, bad = 0, cyc = 0;

  led_bcm_scan #(.NUM_CH(NUM_CH), .COLS(COLS), .ROW_BITS(ROW_BITS), .PWM_DEPTH(D),
                 .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .reset(reset), .en(en), .swap_req(swap_req), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_sel(fb_sel), .fb_rdata(fb_rdata), .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .led_clk(led_clk), .led_stb(led_stb), .led_oe(led_oe), .led_row(led_row),
    .frame_end(frame_end), .swap_ack(swap_ack));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer: data valid only in the cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (fb_rd) fb_rdata <= mem[fb_addr];
    else       fb_rdata <= DW'($urandom);
  end

  logic [2:0] clk_q[$];
  int oe_q[$], stb_row_q[$], stb_cyc_q[$], fe_q[$], rd_q[$], addr_q[$], ack_q[$];
  int run = 0, ghost = 0, sel_glitch = 0;
  logic prev_clk = 1'b0, prev_sel = 1'b0;
  logic [ROW_BITS-1:0] prev_row = '0;

  // Event recorder, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (led_clk && !prev_clk) clk_q.push_back({led_b[0], led_g[0], led_r[0]});
    if (!led_oe) run++;
    else if (run > 0) begin oe_q.push_back(run); run = 0; end
    if (led_stb) begin stb_row_q.push_back(int'(led_row)); stb_cyc_q.push_back(cyc); end
    if (frame_end) fe_q.push_back(cyc);
    if (fb_rd) begin rd_q.push_back(cyc); addr_q.push_back(int'(fb_addr)); end
    if (swap_ack) ack_q.push_back(cyc);
    if (!reset && led_row != prev_row && !led_oe) ghost++;
    if (!reset && fb_sel != prev_sel && !frame_end) sel_glitch++;
    prev_clk = led_clk;
    prev_sel = fb_sel;
    prev_row = led_row;
  end

  function automatic logic [2:0] exp_bits(int row, int plane, int col);
    logic [DW-1:0] w;
    w = mem[row * COLS + col];
    return {w[2*D + plane], w[D + plane], w[plane]};
  endfunction

  task automatic clear_q();
    clk_q.delete(); oe_q.delete(); stb_row_q.delete(); stb_cyc_q.delete();
    fe_q.delete(); rd_q.delete(); addr_q.delete(); ack_q.delete();
    run = 0;
  endtask

  task automatic run_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; swap_req = 1'b0;
    run_cyc(3);
    reset = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
  endtask

  task automatic wait_fe(output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_end === 1'b1) begin at = cyc; break; end
    end
    total++;
    if (at < 0) begin bad++; $display("FAIL frame_end_timeout: got no pulse want one within 400 cycles"); end
  endtask

  task automatic test_reset();
    logic [13:0] obs, want;
    want = 14'b10_0000_0000_0000;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      obs = {led_oe, fb_rd, fb_addr, fb_sel, led_r, led_g, led_b, led_clk, led_stb, led_row,
             frame_end, swap_ack};
      total++;
      if (obs !== want) begin bad++; $display("FAIL reset_idle: got %b want %b", obs, want); end
    end
  endtask

  task automatic test_shift_pattern();
    logic [3:0] got;
    logic [3:0] want [2];
    want[0] = 4'b0000;
    want[1] = 4'b0100;
    do_reset();
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[1] = 6'b00_00_10;
    clear_q();
    en = 1'b1;
    run_cyc(70);
    en = 1'b0;
    total++;
    if (clk_q.size() < 8) begin
      bad++; $display("FAIL pattern_count: got %0d want >=8", clk_q.size());
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < 4; c++) got[3-c] = clk_q[p*4 + c][0];
        total++;
        if (got !== want[p]) begin bad++; $display("FAIL pattern_plane%0d: got %b want %b", p, got, want[p]); end
      end
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (rd_q.size() < 4 || rd_q[i] - rd_q[i-1] != S) begin
        bad++; $display("FAIL fb_rd_spacing: got %0d want %0d", rd_q.size() < 4 ? -1 : rd_q[i] - rd_q[i-1], S);
      end
    end
  endtask

  task automatic test_continuous();
    int row, plane;
    do_reset();
    randomize_mem();
    clear_q();
    en = 1'b1;
    run_cyc(2 * FRAME_LEN + 5);
    en = 1'b0;
    total++;
    if (oe_q.size() < 8 || stb_cyc_q.size() < 8 || clk_q.size() < 32 || fe_q.size() < 2 || addr_q.size() < 12) begin
      bad++; $display("FAIL cont_counts: got oe=%0d stb=%0d clk=%0d fe=%0d rd=%0d", oe_q.size(),
                      stb_cyc_q.size(), clk_q.size(), fe_q.size(), addr_q.size());
    end else begin
      for (int u = 0; u < 8; u++) begin
        row = (u / 2) % 2;
        plane = u % 2;
        total++;
        if (oe_q[u] != (BASE_ON << plane)) begin bad++; $display("FAIL show_width%0d: got %0d want %0d", u, oe_q[u], BASE_ON << plane); end
        total++;
        if (stb_row_q[u] != row) begin bad++; $display("FAIL latch_row%0d: got %0d want %0d", u, stb_row_q[u], row); end
        if (u > 0) begin
          total++;
          if (stb_cyc_q[u] - stb_cyc_q[u-1] != SHIFT_LEN + 1 + BLANK_CYC + (BASE_ON << ((u-1) % 2))) begin
            bad++; $display("FAIL unit_len%0d: got %0d want %0d", u, stb_cyc_q[u] - stb_cyc_q[u-1],
                            SHIFT_LEN + 1 + BLANK_CYC + (BASE_ON << ((u-1) % 2)));
          end
        end
        for (int c = 0; c < COLS; c++) begin
          total++;
          if (clk_q[u*COLS + c] !== exp_bits(row, plane, c)) begin
            bad++; $display("FAIL shift_data u%0d c%0d: got %b want %b", u, c, clk_q[u*COLS + c], exp_bits(row, plane, c));
          end
        end
      end
      for (int i = 0; i < 12; i++) begin
        total++;
        if (addr_q[i] != (i / 8) * COLS + (i % COLS)) begin
          bad++; $display("FAIL fb_addr%0d: got %0d want %0d", i, addr_q[i], (i / 8) * COLS + (i % COLS));
        end
      end
      total++;
      if (fe_q[1] - fe_q[0] != 132) begin bad++; $display("FAIL frame_period: got %0d want 132", fe_q[1] - fe_q[0]); end
      total++;
      if (fe_q[0] - rd_q[0] != FRAME_LEN) begin bad++; $display("FAIL first_frame: got %0d want %0d", fe_q[0] - rd_q[0], FRAME_LEN); end
    end
    total++;
    if (ghost != 0) begin bad++; $display("FAIL ghosting: got %0d row changes with oe on want 0", ghost); end
  endtask

  task automatic test_swap();
    int t1, t3;
    do_reset();
    randomize_mem();
    clear_q();
    en = 1'b1;
    run_cyc(50);
    swap_req = 1'b1;
    run_cyc(1);
    swap_req = 1'b0;
    total++;
    if (fb_sel !== 1'b0) begin bad++; $display("FAIL sel_mid_frame: got %b want 0", fb_sel); end
    wait_fe(t1);
    total++;
    if (swap_ack !== 1'b1 || fb_sel !== 1'b1) begin bad++; $display("FAIL swap_first: got ack=%b sel=%b want 1 1", swap_ack, fb_sel); end
    // request coinciding with the edge that raises the next frame_end
    run_cyc(FRAME_LEN - 1);
    swap_req = 1'b1;
    run_cyc(1);
    swap_req = 1'b0;
    total++;
    if (frame_end !== 1'b1 || swap_ack !== 1'b1 || fb_sel !== 1'b0) begin
      bad++; $display("FAIL swap_boundary: got fe=%b ack=%b sel=%b want 1 1 0", frame_end, swap_ack, fb_sel);
    end
    wait_fe(t3);
    total++;
    if (swap_ack !== 1'b0 || fb_sel !== 1'b0) begin bad++; $display("FAIL no_swap: got ack=%b sel=%b want 0 0", swap_ack, fb_sel); end
    total++;
    if (ack_q.size() != 2 || ack_q[0] != t1) begin bad++; $display("FAIL ack_events: got %0d want 2", ack_q.size()); end
    total++;
    if (sel_glitch != 0) begin bad++; $display("FAIL sel_glitch: got %0d want 0", sel_glitch); end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    do_reset();
    randomize_mem();
    clear_q();
    en = 1'b1;
    run_cyc(10);
    en = 1'b0;
    run_cyc(60);
    total++;
    if (oe_q.size() != 1 || oe_q[0] != 4) begin bad++; $display("FAIL drop_show: got n=%0d want one 4-cycle show", oe_q.size()); end
    total++;
    if (led_oe !== 1'b1 || rd_q.size() != COLS) begin bad++; $display("FAIL drop_idle: got oe=%b reads=%0d want 1 %0d", led_oe, rd_q.size(), COLS); end
    clear_q();
    en = 1'b1;
    run_cyc(40);
    en = 1'b0;
    run_cyc(5);
    total++;
    if (oe_q.size() < 1 || stb_row_q.size() < 1 || clk_q.size() < COLS) begin
      bad++; $display("FAIL resume_counts: got oe=%0d stb=%0d clk=%0d", oe_q.size(), stb_row_q.size(), clk_q.size());
    end else begin
      total++;
      if (oe_q[0] != 8 || stb_row_q[0] != 0) begin bad++; $display("FAIL resume_unit: got show=%0d row=%0d want 8 0", oe_q[0], stb_row_q[0]); end
      for (int c = 0; c < COLS; c++) begin
        total++;
        if (clk_q[c] !== exp_bits(0, 1, c)) begin bad++; $display("FAIL resume_data c%0d: got %b want %b", c, clk_q[c], exp_bits(0, 1, c)); end
      end
    end
    total++;
    if (fe_q.size() != 0) begin bad++; $display("FAIL resume_fe: got %0d want 0", fe_q.size()); end
  endtask

  task automatic test_reset_in_show();
    int t1;
    bit hit;
    logic [4:0] obs;
    do_reset();
    randomize_mem();
    clear_q();
    en = 1'b1;
    swap_req = 1'b1;
    run_cyc(1);
    swap_req = 1'b0;
    wait_fe(t1);
    total++;
    if (fb_sel !== 1'b1) begin bad++; $display("FAIL pre_reset_sel: got %b want 1", fb_sel); end
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (led_oe === 1'b0 && led_row === 1'b1) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL show_row1_timeout: got none want a row-1 show"); end
    reset = 1'b1;
    run_cyc(1);
    obs = {led_oe, led_row, fb_sel, fb_rd, led_stb};
    total++;
    if (obs !== 5'b10000) begin bad++; $display("FAIL reset_in_show: got %b want 10000", obs); end
    clear_q();
    reset = 1'b0;
    run_cyc(40);
    total++;
    if (oe_q.size() < 1 || stb_row_q.size() < 1 || clk_q.size() < COLS || addr_q.size() < 1) begin
      bad++; $display("FAIL restart_counts: got oe=%0d stb=%0d clk=%0d", oe_q.size(), stb_row_q.size(), clk_q.size());
    end else begin
      total++;
      if (oe_q[0] != 4 || stb_row_q[0] != 0 || addr_q[0] != 0) begin
        bad++; $display("FAIL restart_unit: got show=%0d row=%0d addr=%0d want 4 0 0", oe_q[0], stb_row_q[0], addr_q[0]);
      end
      for (int c = 0; c < COLS; c++) begin
        total++;
        if (clk_q[c] !== exp_bits(0, 0, c)) begin bad++; $display("FAIL restart_data c%0d: got %b want %b", c, clk_q[c], exp_bits(0, 0, c)); end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; swap_req = 1'b0;
    test_reset();
    test_shift_pattern();
    test_continuous();
    test_swap();
    test_en_drop();
    test_reset_in_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
